// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: operation selects, multiply/divide
// sequencer states and the default word width.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the
// remainder/quotient pair left, trial-subtract the divisor, keep the
// difference and set the quotient bit only when it did not go negative.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Remainder shifted by one with the next dividend bit taken from the
    // quotient MSB; one extra bit so the trial subtract exposes a borrow.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_i};

    // Restore on borrow, otherwise accept the difference and record a 1.
    always_comb begin
        if (diff[WIDTH]) begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes with sign fix-up) unit holding the architectural HI/LO pair.
// Handshake: start is sampled only while idle; busy is high from the
// accepting edge until the edge that raises the one-cycle done pulse.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output muldiv_state_t      state_o
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t    state_q, state_d;
    // mcand holds the multiplicand for mult and the divisor magnitude for div.
    logic [WIDTH-1:0] mcand_q, mcand_d;
    // acc_hi/acc_lo: Booth product halves for mult, remainder/quotient for div.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dzo_q, dzo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] div_rem, div_quo;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // Booth add/subtract on the sign-extended upper half.
    always_comb begin
        booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q};
        case ({acc_lo_q[0], qm1_q})
            2'b01:   booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q} + {mcand_q[WIDTH-1], mcand_q};
            2'b10:   booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q} - {mcand_q[WIDTH-1], mcand_q};
            default: ;
        endcase
    end

    div_restore_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (acc_hi_q),
        .quo_i (acc_lo_q),
        .dvs_i (mcand_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );

    // Sequencer next state and datapath updates.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dzo_d     = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    qm1_d    = 1'b0;
                    if (op == OP_MULT) begin
                        mcand_d  = a;
                        acc_lo_d = b;
                        state_d  = MULT;
                    end else begin
                        mcand_d   = b_mag;
                        acc_lo_d  = a_mag;
                        neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_d = a[WIDTH-1];
                        if (b == '0) begin
                            dz_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = DIV;
                        end
                    end
                end
            end
            MULT: begin
                // Arithmetic shift right of {P_hi, P_lo, q-1} after the add.
                acc_hi_d = booth_sum[WIDTH:1];
                acc_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
                qm1_d    = acc_lo_q[0];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            DIV: begin
                acc_hi_d = div_rem;
                acc_lo_d = div_quo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                // Truncating division: quotient sign from a^b, remainder from a.
                if (neg_quo_q) acc_lo_d = -acc_lo_q;
                if (neg_rem_q) acc_hi_d = -acc_hi_q;
                state_d = DONE;
            end
            DONE: begin
                if (!dz_q) begin
                    hi_d = acc_hi_q;
                    lo_d = acc_lo_q;
                end
                done_d  = 1'b1;
                dzo_d   = dz_q;
                dz_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dzo_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dzo_q     <= dzo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized back-to-back
// operations checked against an arithmetic reference of HI/LO and latency.
module tb_mult_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic [W-1:0]  a, b;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;
    muldiv_state_t state_o;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo),
        .state_o  (state_o)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output logic dz);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        if (o == OP_MULT) begin
            p = sx * sy;
            m_hi = p[63:32];
            m_lo = p[31:0];
            lat = W + 1;
        end else if (y == '0) begin
            dz = 1'b1;
            lat = 1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            m_hi = r[31:0];
            m_lo = q[31:0];
            lat = W + 2;
        end
        exp_q.push_back(m_hi);
        exp_q.push_back(m_lo);
    endtask

    // Issue one operation, optionally re-pulse start at E0+inject_at, check result.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int inject_at, input string tag);
        int          lat_exp, lat, busy_cnt;
        logic        dz_exp;
        logic [W-1:0] eh, el;
        model(o, x, y, lat_exp, dz_exp);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
        check({tag, " busy_after_accept"}, 64'(busy), 64'(1'b1));
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            start = (k == inject_at);
            if (k == inject_at) begin
                a = $urandom; b = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        eh = exp_q.pop_front();
        el = exp_q.pop_front();
        check({tag, " latency"}, 64'(lat), 64'(lat_exp));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat_exp - 1));
        check({tag, " busy_at_done"}, 64'(busy), 64'(1'b0));
        check({tag, " div_zero"}, 64'(div_zero), 64'(dz_exp));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'({done, div_zero}), 64'(2'b00));
    endtask

    initial begin
        int           nd;
        logic         ro;
        logic [W-1:0] rx, ry;

        // Reset.
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'(1'b0));
        check("reset done", 64'({done, div_zero}), 64'(2'b00));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset state", 64'(state_o), 64'(IDLE));
        reset = 1'b0;

        // Directed cases.
        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0, "mult_7x-3");
        check("mult_7x-3 hi const", 64'(hi), 64'(32'hFFFF_FFFF));
        check("mult_7x-3 lo const", 64'(lo), 64'(32'hFFFF_FFEB));
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, "mult_min_min");
        check("mult_min_min hi const", 64'(hi), 64'(32'h4000_0000));
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, "div_-7/2");
        check("div_-7/2 lo const", 64'(lo), 64'(32'hFFFF_FFFD));
        check("div_-7/2 hi const", 64'(hi), 64'(32'hFFFF_FFFF));
        run_op(OP_DIV, 32'h0000_2211, 32'h0000_0100, 0, "div_setup");
        run_op(OP_DIV, 32'd5, 32'd0, 0, "div_by_zero");
        check("div_by_zero hi held", 64'(hi), 64'(32'h11));
        check("div_by_zero lo held", 64'(lo), 64'(32'h22));
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_min/-1");
        check("div_min/-1 lo const", 64'(lo), 64'(32'h8000_0000));
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) nd++;
        end
        check("ignored_start no_extra_done", 64'(nd), 64'(0));

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset busy", 64'(busy), 64'(1'b0));
        check("midreset hi", 64'(hi), 64'(0));
        check("midreset lo", 64'(lo), 64'(0));
        check("midreset state", 64'(state_o), 64'(IDLE));
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) nd++;
        end
        check("midreset no_done", 64'(nd), 64'(0));
        run_op(OP_MULT, 32'd3, 32'd4, 0, "mult_3x4");
        check("mult_3x4 lo const", 64'(lo), 64'(12));
        check("mult_3x4 hi const", 64'(hi), 64'(0));

        // Randomized back-to-back operations with corner operands mixed in.
        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = '0;
                1: rx = 32'h8000_0000;
                2: ry = 32'hFFFF_FFFF;
                3: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, rx, ry, 0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
